// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO: frames LSB first at CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); the default build is 8N1.
module uart_tx_fifo #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       send,
    input  logic [N-1:0]               data_in,
    output logic                       tx,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [NW-1:0]   bit_q, bit_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tx_q, tx_d, busy_q, busy_d, overflow_q, overflow_d;
    logic [N-1:0]    mem_q [DEPTH];
    logic            pop, push, fifo_empty, fifo_full, baud_last;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign baud_last  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        baud_d  = (state_q == S_IDLE || baud_last) ? '0 : baud_q + BW'(1);
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (baud_last) state_d = S_DATA;
            S_DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + NW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (baud_last) state_d = S_STOP;
`endif
            S_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop loads the head word and restarts the bit counter; baud_d is already zero here.
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_comb begin
        push       = send && (!fifo_full || pop);
        overflow_d = send && fifo_full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // tx is registered from the next state so the line changes on the same edge as the FSM.
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
    assign done       = (state_q == S_STOP) && baud_last;
endmodule
